ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 4, RAM word width; DEPTH, default 16, RAM word count; AW, default $clog2(DEPTH), address width (derived).
REQ-002 Ports SHALL be (one per line, clock and reset first):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  req[1:0]  in  2  per-requester access request
  we[1:0]  in  2  per-requester write strobe (1=write, 0=read)
  addr0, addr1  in  AW each  per-requester address
  wdata0, wdata1  in  DATA_WIDTH each  per-requester write data
  gnt[1:0]  out  2  access granted this cycle (one-hot or zero)
  rvalid[1:0]  out  2  read data valid for requester
  rdata  out  DATA_WIDTH  shared read data bus
  busy  out  1  arbiter not accepting requests
REQ-003 The design SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.

Function
REQ-004 gnt SHALL be combinational from req, the round-robin pointer and state, and SHALL have at most one bit set.
REQ-005 When exactly one req bit is set in state RUN, that requester SHALL be granted.
REQ-006 When both req bits are set, the requester indicated by pointer rr SHALL be granted; rr SHALL toggle to the other requester on the same clock edge.
REQ-007 rr SHALL NOT change in a cycle with no grant or a single uncontested grant.
REQ-008 A requester SHALL hold req, we, addr and wdata stable until gnt is seen; each gnt cycle SHALL complete exactly one access.
REQ-009 Granted write: the RAM SHALL capture wdata at addr on the grant edge.
REQ-010 Granted read: rvalid[i] SHALL assert for exactly one cycle, the cycle after gnt[i], with rdata holding memory[addr] from the grant cycle.
REQ-011 rdata SHALL be don't-care when rvalid is zero.
REQ-012 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-013 Back-to-back grants SHALL be allowed every cycle, giving full throughput.
REQ-014 FSM states SHALL be CLEAR (only when the REQ-018 feature is compiled in) and RUN.
REQ-015 In RUN, busy SHALL be 0.

Reset
REQ-016 On rst_n low, the block SHALL set gnt=0, rvalid=0, rdata=0 and rr=0 (requester 0 first).
REQ-017 Reset SHALL abort any in-flight read: no rvalid pulse after reset release for a read granted before reset. RAM contents SHALL be unaffected by reset unless REQ-018 applies.

Configuration
REQ-018 With RAM_ARB_CLEAR_EN defined, the behaviour SHALL be:
  - after reset release, the FSM enters CLEAR
  - a clear counter writes 0 to addresses 0..DEPTH-1, one per cycle
  - busy=1 and gnt=0 throughout CLEAR
  - the FSM enters RUN after the last address (DEPTH cycles)
  - reset during CLEAR restarts the sweep at address 0
REQ-019 Without RAM_ARB_CLEAR_EN, the FSM SHALL enter RUN on the first edge after reset release, and there SHALL be no clear counter logic.

Structure
REQ-020 The shared package ram_pkg SHALL hold the state enum (CLEAR, RUN), the requester-count constant NREQ=2, and the default DATA_WIDTH and DEPTH.
REQ-021 The storage SHALL be one instance of the existing ram16x4 sub-module (synchronous write, registered read); the arbiter SHALL drive its write_enable, addr and data_in.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Single write then read: req0 writes 4'hA at addr 3, then req0 reads addr 3 -> gnt0 each cycle; rvalid0=1 with rdata=4'hA one cycle after the read grant.
  - Contention: req=2'b11 for 4 cycles from reset, both reading -> gnt sequence 01,10,01,10; rvalid follows one cycle later per owner.
  - Read-after-write: req1 writes 4'h5 at addr 15, req0 reads addr 15 next cycle -> rdata=4'h5.
  - Reset mid-read: rst_n low in the cycle after gnt0 for a read -> rvalid stays 0; after release, rr=0.
  - RAM_ARB_CLEAR_EN: preload garbage, pulse reset -> busy=1 for 16 cycles with gnt=0 despite req=2'b11; then reads of addr 0..15 return 0.
  - No request: req=0 for 10 cycles -> gnt=0, rvalid=0, rr unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared declarations for the two-port RAM arbiter: FSM state
//               encoding, requester count and default RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

    // CLEAR is only ever entered when the power-on clear sweep is compiled in
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int NREQ               = 2;
    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_DEPTH      = 16;

endpackage : ram_pkg

`default_nettype wire

// File: rtl/ram16x4.sv
// ============================================================================
// Module      : ram16x4
// Description : Single-port RAM, synchronous write, registered read.
//               The read register samples memory before the same-edge write
//               lands (old-data read).
// Ports       : clk          - clock, rising edge
//               write_enable - write data_in to addr on the rising edge
//               addr         - word address
//               data_in      - write data
//               data_out     - registered read data (memory[addr] of the
//                              previous cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram16x4 #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  write_enable,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Storage array and read register; deliberately not reset
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem_q[addr] <= data_in;
        end
        data_out_q <= mem_q[addr];
    end

    assign data_out = data_out_q;

endmodule : ram16x4

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module      : ram_port_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               RAM. One access is granted per cycle; reads return data one
//               cycle after the grant with a one-cycle rvalid pulse.
// Config      : RAM_ARB_CLEAR_EN - when defined, a post-reset sweep writes 0
//               to every RAM word (busy=1, no grants) before entering RUN.
// Ports       : clk            - clock, rising edge
//               rst_n          - asynchronous active-low reset
//               req[1:0]       - per-requester access request
//               we[1:0]        - per-requester write strobe (1=write)
//               addr0, addr1   - per-requester address
//               wdata0, wdata1 - per-requester write data
//               gnt[1:0]       - combinational grant, one-hot or zero
//               rvalid[1:0]    - read data valid for requester
//               rdata          - shared read data bus
//               busy           - arbiter not accepting requests
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       we,
    input  logic [AW-1:0]         addr0,
    input  logic [AW-1:0]         addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

`ifdef RAM_ARB_CLEAR_EN
    localparam state_e RESET_STATE = CLEAR;
`else
    localparam state_e RESET_STATE = RUN;
`endif

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [NREQ-1:0]       rvalid_q, rvalid_d;
`ifdef RAM_ARB_CLEAR_EN
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
`endif

    logic                  w_run;
    logic                  w_clearing;
    logic [NREQ-1:0]       w_gnt;
    logic                  w_ram_we;
    logic [AW-1:0]         w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Gating with rst_n keeps gnt at zero while reset is held, even in
    // builds where the reset state is already RUN.
    assign w_run = rst_n && (state_q == RUN);

`ifdef RAM_ARB_CLEAR_EN
    assign w_clearing = rst_n && (state_q == CLEAR);
`else
    assign w_clearing = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant: single requester wins outright; on contention rr picks.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt = '0;
        if (w_run) begin
            unique case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = rr_q ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt = w_gnt;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        rvalid_d = w_gnt & ~we;

        // rr only moves when it actually decided a contested grant
        if (w_run && (req == 2'b11)) begin
            rr_d = ~rr_q;
        end

`ifdef RAM_ARB_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
`else
        state_d = RUN;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            rr_q      <= 1'b0;
            rvalid_q  <= '0;
`ifdef RAM_ARB_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            rvalid_q  <= rvalid_d;
`ifdef RAM_ARB_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux: clear sweep has priority, else the granted requester.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_addr  = addr0;
        w_ram_wdata = wdata0;
        if (w_clearing) begin
`ifdef RAM_ARB_CLEAR_EN
            w_ram_addr = clr_cnt_q;
`endif
            w_ram_wdata = '0;
        end else if (w_gnt[1]) begin
            w_ram_addr  = addr1;
            w_ram_wdata = wdata1;
        end
    end

    assign w_ram_we = w_clearing || (|(w_gnt & we));

    ram16x4 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk          (clk),
        .write_enable (w_ram_we),
        .addr         (w_ram_addr),
        .data_in      (w_ram_wdata),
        .data_out     (w_ram_rdata)
    );

    // The RAM read register has no reset, so rdata is forced to zero
    // whenever no read is being returned (including throughout reset).
    assign rvalid = rvalid_q;
    assign rdata  = (|rvalid_q) ? w_ram_rdata : '0;
    assign busy   = (state_q != RUN);

endmodule : ram_port_arbiter

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench for ram_port_arbiter.
//               Define RAM_ARB_CLEAR_EN to exercise the clear-sweep build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic       BUSY_IN_RST = 1'b1;
    localparam logic [3:0] MEM3_AFTER  = 4'h0;   // RAM cleared by each reset
`else
    localparam logic       BUSY_IN_RST = 1'b0;
    localparam logic [3:0] MEM3_AFTER  = 4'hA;   // RAM survives reset
`endif

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          busy;

    int errors = 0;
    int checks = 0;

    ram_port_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One bus cycle: drive at negedge, check grant before the edge,
    // check read return just after the edge.
    task automatic step(input string tag, input logic [1:0] r, input logic [1:0] w,
                        input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] d0, input logic [3:0] d1,
                        input logic [1:0] eg, input logic [1:0] ev,
                        input logic [3:0] ed);
        @(negedge clk);
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #1;
        chk({tag, "_gnt"}, 8'(gnt), 8'(eg));
        chk({tag, "_busy"}, 8'(busy), 8'h0);
        @(posedge clk);
        #1;
        chk({tag, "_rvalid"}, 8'(rvalid), 8'(ev));
        if (ev != 2'b00) chk({tag, "_rdata"}, 8'(rdata), 8'(ed));
    endtask

    task automatic wait_clear();
`ifdef RAM_ARB_CLEAR_EN
        repeat (DEPTH) @(posedge clk);
`endif
    endtask

    // Hold reset with both requesting: nothing may be granted.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; req = 2'b11; we = 2'b00;
        @(negedge clk);
        #1;
        chk({tag, "_gnt"}, 8'(gnt), 8'h0);
        chk({tag, "_rvalid"}, 8'(rvalid), 8'h0);
        chk({tag, "_rdata"}, 8'(rdata), 8'h0);
        chk({tag, "_busy"}, 8'(busy), 8'(BUSY_IN_RST));
        @(negedge clk);
        rst_n = 1'b1; req = 2'b00;
        wait_clear();
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        do_reset("rst0");

        // Single write then read by requester 0
        step("wr0",   2'b01, 2'b01, 4'd3, 4'd0, 4'hA, 4'h0, 2'b01, 2'b00, 4'h0);
        step("rd0",   2'b01, 2'b00, 4'd3, 4'd0, 4'h0, 4'h0, 2'b01, 2'b01, 4'hA);
        step("idle0", 2'b00, 2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);

        // Contention from reset: rr starts at requester 0 and alternates
        do_reset("rst1");
        step("con0", 2'b11, 2'b00, 4'd3, 4'd3, 4'h0, 4'h0, 2'b01, 2'b01, MEM3_AFTER);
        step("con1", 2'b11, 2'b00, 4'd3, 4'd3, 4'h0, 4'h0, 2'b10, 2'b10, MEM3_AFTER);
        step("con2", 2'b11, 2'b00, 4'd3, 4'd3, 4'h0, 4'h0, 2'b01, 2'b01, MEM3_AFTER);
        step("con3", 2'b11, 2'b00, 4'd3, 4'd3, 4'h0, 4'h0, 2'b10, 2'b10, MEM3_AFTER);

        // Read-after-write across requesters
        step("raw_wr", 2'b10, 2'b10, 4'd0, 4'd15, 4'h0, 4'h5, 2'b10, 2'b00, 4'h0);
        step("raw_rd", 2'b01, 2'b00, 4'd15, 4'd0, 4'h0, 4'h0, 2'b01, 2'b01, 4'h5);

        // rr held through idle cycles: set rr=1, idle, contend -> requester 1
        step("rr_set", 2'b11, 2'b00, 4'd15, 4'd15, 4'h0, 4'h0, 2'b01, 2'b01, 4'h5);
        for (int i = 0; i < 10; i++)
            step("idle", 2'b00, 2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);
        step("rr_hold", 2'b11, 2'b00, 4'd15, 4'd15, 4'h0, 4'h0, 2'b10, 2'b10, 4'h5);

        // Reset mid-read: rr=1 beforehand, read granted, reset right after
        step("pre_rr", 2'b11, 2'b00, 4'd3, 4'd3, 4'h0, 4'h0, 2'b01, 2'b01, MEM3_AFTER);
        @(negedge clk);
        req = 2'b01; we = 2'b00; addr0 = 4'd3;
        #1;
        chk("mid_gnt", 8'(gnt), 8'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0; req = 2'b00;
        #2;
        chk("mid_rvalid_a", 8'(rvalid), 8'h0);
        @(negedge clk);
        chk("mid_rvalid_b", 8'(rvalid), 8'h0);
        chk("mid_rdata", 8'(rdata), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear();
        step("post_rst", 2'b00, 2'b00, 4'd0, 4'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);
        step("rr_rst",   2'b11, 2'b00, 4'd3, 4'd3, 4'h0, 4'h0, 2'b01, 2'b01, MEM3_AFTER);

`ifdef RAM_ARB_CLEAR_EN
        // Preload garbage everywhere
        for (int i = 0; i < DEPTH; i++)
            step("pre", 2'b01, 2'b01, 4'(i), 4'd0, 4'hF, 4'h0, 2'b01, 2'b00, 4'h0);
        // Reset, partial sweep, reset again: sweep must restart from zero
        @(negedge clk);
        rst_n = 1'b0; req = 2'b11; we = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("clr_part_busy", 8'(busy), 8'h1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("clr_busy", 8'(busy), 8'h1);
            chk("clr_gnt", 8'(gnt), 8'h0);
            @(negedge clk);
        end
        #1;
        chk("clr_done_busy", 8'(busy), 8'h0);
        chk("clr_done_gnt", 8'(gnt), 8'h1);
        req = 2'b00;
        for (int i = 0; i < DEPTH; i++)
            step("clr_rd", 2'b01, 2'b00, 4'(i), 4'd0, 4'h0, 4'h0, 2'b01, 2'b01, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ram_port_arbiter

`default_nettype wire
